// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arithmetic/shift ops plus a 32-iteration
// radix-2 shift-add multiplier. All results are registered and flagged by a done pulse.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o
);

    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_SLL  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_SRAI = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [5:0]       r_cnt;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_data;
    logic             r_done;
    logic             r_zero;

    logic             w_accept;
    logic             w_mul_last;
    logic             w_complete;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_result;

    function automatic logic [WIDTH-1:0] alu_op(input logic [2:0]       op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        sa = a;
        case (op)
            OP_AND:  alu_op = a & b;
            OP_XOR:  alu_op = a ^ b;
            OP_SLL:  alu_op = a << b[4:0];
            OP_ADD:  alu_op = a + b;
            OP_SUB:  alu_op = a - b;
            OP_SRAI: alu_op = sa >>> b[4:0];
            default: alu_op = '0;
        endcase
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_mul_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_accept = 1'b1;
                    if (ALUCtrl_i == OP_MUL) begin
                        w_state_nxt = S_MUL;
                    end
                end
            end
            S_MUL: begin
                if (r_cnt == 6'd31) begin
                    w_mul_last  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One shift-add step: the final step's sum is the product, so it feeds the result directly.
    assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_complete = (w_accept && (ALUCtrl_i != OP_MUL)) || w_mul_last;
    assign w_result   = w_mul_last ? w_acc_nxt : alu_op(ALUCtrl_i, data1_i, data2_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_data  <= '0;
            r_zero  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_complete;
            if (w_accept || w_mul_last) begin
                r_cnt <= '0;
            end else if (r_state == S_MUL) begin
                r_cnt <= r_cnt + 6'd1;
            end
            if (w_complete) begin
                r_data <= w_result;
                r_zero <= (w_result == '0);
            end
        end
    end

    // Operand copies are private to the multiplier, so later input changes cannot disturb it.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_mcand  <= data1_i;
            r_mplier <= data2_i;
            r_acc    <= '0;
        end else if (r_state == S_MUL) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign busy_o = (r_state == S_MUL);
    assign done_o = r_done;
    assign data_o = r_data;
    assign zero_o = r_zero;

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu: reset, single-cycle ops, back-to-back issue,
// multiply timing, reset abort, and nop.
module tb_seq_alu;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_SLL  = 3'b011;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_SRAI = 3'b111;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        busy;
    logic        done;
    logic [31:0] dout;
    logic        zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .ALUCtrl_i(op),
        .data1_i  (d1),
        .data2_i  (d2),
        .busy_o   (busy),
        .done_o   (done),
        .data_o   (dout),
        .zero_o   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; op = OP_NOP; d1 = '0; d2 = '0;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", dout); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got %b want 1", zero); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_add;
        rst = 1'b0; op = OP_ADD; d1 = 32'd5; d2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if (dout !== 32'd12) begin n_fail++; $display("FAIL add_data got %h want 0000000c", dout); end
        n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL add_zero got %b want 0", zero); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL add_done got %b want 1", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL add_busy got %b want 0", busy); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_done_drop got %b want 0", done); end
        n_checks++; if (dout !== 32'd12) begin n_fail++; $display("FAIL add_hold got %h want 0000000c", dout); end
    endtask

    task automatic test_back_to_back;
        op = OP_SUB; d1 = 32'd3; d2 = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (dout !== 32'h0) begin n_fail++; $display("FAIL sub0_data got %h want 00000000", dout); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL sub0_zero got %b want 1", zero); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL sub0_done got %b want 1", done); end
        d1 = 32'd0; d2 = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if (dout !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sub1_data got %h want ffffffff", dout); end
        n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL sub1_zero got %b want 0", zero); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL sub1_done got %b want 1", done); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop got %b want 0", done); end
    endtask

    task automatic test_logic_shift;
        logic [2:0]  ops  [6] = '{OP_SRAI, OP_SLL, OP_AND, OP_XOR, OP_ADD, OP_SRAI};
        logic [31:0] a    [6] = '{32'h8000_0000, 32'h0000_0001, 32'hF0F0_1234, 32'hAAAA_5555, 32'hFFFF_FFFF, 32'h4000_0000};
        logic [31:0] b    [6] = '{32'h0000_0024, 32'd31, 32'h0FF0_FFFF, 32'hFFFF_0000, 32'h0000_0002, 32'd3};
        logic [31:0] want [6] = '{32'hF800_0000, 32'h8000_0000, 32'h00F0_1234, 32'h5555_5555, 32'h0000_0001, 32'h0800_0000};
        for (int i = 0; i < 6; i++) begin
            op = ops[i]; d1 = a[i]; d2 = b[i]; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n_checks++;
            if (dout !== want[i] || done !== 1'b1) begin
                n_fail++;
                $display("FAIL op_vec%0d got data=%h done=%b want data=%h done=1", i, dout, done, want[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want,
                           input logic want_zero, input string tag);
        logic [31:0] prev;
        int edges;
        int busy_cycles;
        bit early;
        prev = dout; edges = 0; busy_cycles = 0; early = 1'b0;
        op = OP_MUL; d1 = a; d2 = b; start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) begin
                op = OP_ADD; d1 = 32'h1234_5678; d2 = 32'h0000_0009;
            end
            if (busy) busy_cycles++;
            if (done) break;
            if (dout !== prev) early = 1'b1;
        end
        start = 1'b0;
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL %s_timeout done=%b after %0d edges", tag, done, edges); end
        n_checks++; if (edges != 33) begin n_fail++; $display("FAIL %s_latency got %0d want 33", tag, edges); end
        n_checks++; if (busy_cycles != 32) begin n_fail++; $display("FAIL %s_busy_cycles got %0d want 32", tag, busy_cycles); end
        n_checks++; if (early) begin n_fail++; $display("FAIL %s_data_changed_while_busy got 1 want 0", tag); end
        n_checks++; if (dout !== want) begin n_fail++; $display("FAIL %s_data got %h want %h", tag, dout, want); end
        n_checks++; if (zero !== want_zero) begin n_fail++; $display("FAIL %s_zero got %b want %b", tag, zero, want_zero); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL %s_after got done=%b busy=%b want 0 0", tag, done, busy); end
        n_checks++; if (dout !== want) begin n_fail++; $display("FAIL %s_hold got %h want %h", tag, dout, want); end
    endtask

    task automatic test_mul;
        run_mul(32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b0, "mul_m1x3");
        run_mul(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, "mul_wrap");
        run_mul(32'd7, 32'd6, 32'd42, 1'b0, "mul_7x6");
    endtask

    task automatic test_mul_reset;
        bit seen_done;
        seen_done = 1'b0;
        op = OP_MUL; d1 = 32'd1000; d2 = 32'd1000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", done); end
        n_checks++; if (dout !== 32'h0) begin n_fail++; $display("FAIL abort_data got %h want 00000000", dout); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL abort_zero got %b want 1", zero); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen_done = 1'b1;
        end
        n_checks++; if (seen_done) begin n_fail++; $display("FAIL abort_late_activity got 1 want 0"); end
        op = OP_ADD; d1 = 32'd1; d2 = 32'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if (dout !== 32'd2 || done !== 1'b1) begin n_fail++; $display("FAIL post_reset_add got data=%h done=%b want 00000002 1", dout, done); end
    endtask

    task automatic test_nop;
        op = OP_NOP; d1 = 32'd5; d2 = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++; if (dout !== 32'h0) begin n_fail++; $display("FAIL nop_data got %h want 00000000", dout); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL nop_zero got %b want 1", zero); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL nop_done got %b want 1", done); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL nop_done_drop got %b want 0", done); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_logic_shift();
        test_mul();
        test_mul_reset();
        test_nop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
